pattern_vg_multi: RTL and testbench



---
 rtl/pattern_vg_pkg.sv | 32 +++
 rtl/pvg_coord_cnt.sv | 87 ++++++++
 rtl/pattern_vg_multi.sv | 154 +++++++++++++++
 tb/tb_pattern_vg_multi.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_vg_pkg.sv
// Shared mode encodings, bar colour table and pipeline latency for the video test-pattern generator.
package pattern_vg_pkg;

    localparam int PVG_LATENCY = 2;

    typedef enum logic [2:0] {
        MODE_SOLID = 3'd0,
        MODE_BARS  = 3'd1,
        MODE_RAMP  = 3'd2,
        MODE_CHECK = 3'd3,
        MODE_GRID  = 3'd4,
        MODE_MOVE  = 3'd5,
        MODE_OFF   = 3'd6
    } pvg_mode_e;

    // {R,G,B} full/zero flags, left to right: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] f;
        case (idx)
            3'd0:    f = 3'b111;
            3'd1:    f = 3'b110;
            3'd2:    f = 3'b011;
            3'd3:    f = 3'b010;
            3'd4:    f = 3'b101;
            3'd5:    f = 3'b100;
            3'd6:    f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pvg_coord_cnt.sv
// Pixel/line coordinate tracker: vs/de edge detection, x/y counters, frame counter and moving-bar position.
// x/y are the coordinates of the pixel currently on the input bus; frame_start is a one-cycle pulse.
module pvg_coord_cnt #(
    parameter int X_BITS    = 13,
    parameter int Y_BITS    = 13,
    parameter int H_ACT     = 1280,
    parameter int MOVE_STEP = 4
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              de_in,
    output logic [X_BITS-1:0] x_o,
    output logic [Y_BITS-1:0] y_o,
    output logic [X_BITS-1:0] bar_pos_o,
    output logic              frame_start_o
);

    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [X_BITS-1:0] bar_q, bar_d;
    logic [X_BITS:0]   bar_sum;
    logic              frame_start;
    logic              de_fall;

    assign frame_start = vs_in & ~vs_q;
    assign de_fall     = de_q & ~de_in;
    assign bar_sum     = {1'b0, bar_q} + (X_BITS+1)'(MOVE_STEP);

    always_comb begin
        vs_d = vs_in;
        de_d = de_in;

        x_d = x_q;
        if (de_fall) begin
            x_d = '0;
        end else if (de_in && (x_q != {X_BITS{1'b1}})) begin
            x_d = x_q + 1'b1;
        end

        // A frame start outranks a line end landing in the same cycle
        y_d = y_q;
        if (frame_start) begin
            y_d = '0;
        end else if (de_fall && (y_q != {Y_BITS{1'b1}})) begin
            y_d = y_q + 1'b1;
        end

        frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;

        bar_d = bar_q;
        if (frame_start) begin
            if (bar_sum >= (X_BITS+1)'(H_ACT)) begin
                bar_d = X_BITS'(bar_sum - (X_BITS+1)'(H_ACT));
            end else begin
                bar_d = X_BITS'(bar_sum);
            end
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            bar_q       <= '0;
        end else begin
            vs_q        <= vs_d;
            de_q        <= de_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            bar_q       <= bar_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign bar_pos_o     = bar_q;
    assign frame_start_o = frame_start;

endmodule

// File: rtl/pattern_vg_multi.sv
// Multi-mode video test-pattern generator with a fixed 2-cycle sync/data pipeline.
// Optional PATTERN_VG_BORDER_EN forces a one-pixel white frame border in every mode.
module pattern_vg_multi
    import pattern_vg_pkg::*;
#(
    parameter int COLOR_DEPTH = 8,
    parameter int X_BITS      = 13,
    parameter int Y_BITS      = 13,
    parameter int H_ACT       = 1280,
    parameter int V_ACT       = 720,
    parameter int CHECK_LOG2  = 5,
    parameter int GRID_LOG2   = 6,
    parameter int RAMP_SHIFT  = 2,
    parameter int MOVE_STEP   = 4
) (
    input  logic                     pix_clk,
    input  logic                     rst,
    input  logic [2:0]               mode_in,
    input  logic [3*COLOR_DEPTH-1:0] color_in,
    input  logic                     vs_in,
    input  logic                     hs_in,
    input  logic                     de_in,
    output logic                     vs_out,
    output logic                     hs_out,
    output logic                     de_out,
    output logic [COLOR_DEPTH-1:0]   r_out,
    output logic [COLOR_DEPTH-1:0]   g_out,
    output logic [COLOR_DEPTH-1:0]   b_out
);

    localparam int                       BAR_W = H_ACT / 8;
    localparam logic [3*COLOR_DEPTH-1:0] WHITE = {(3*COLOR_DEPTH){1'b1}};

    logic [X_BITS-1:0] x_cnt;
    logic [Y_BITS-1:0] y_cnt;
    logic [X_BITS-1:0] bar_pos;
    logic              frame_start;

    pvg_coord_cnt #(
        .X_BITS    (X_BITS),
        .Y_BITS    (Y_BITS),
        .H_ACT     (H_ACT),
        .MOVE_STEP (MOVE_STEP)
    ) u_coord (
        .pix_clk       (pix_clk),
        .rst           (rst),
        .vs_in         (vs_in),
        .de_in         (de_in),
        .x_o           (x_cnt),
        .y_o           (y_cnt),
        .bar_pos_o     (bar_pos),
        .frame_start_o (frame_start)
    );

    pvg_mode_e                mode_q, mode_d;
    logic [3*COLOR_DEPTH-1:0] color_q, color_d;
    logic [X_BITS-1:0]        x1_q, x1_d;
    logic [Y_BITS-1:0]        y1_q, y1_d;
    logic                     de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic                     de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [3*COLOR_DEPTH-1:0] rgb2_q, rgb2_d;

    logic [2:0]               bar_idx;
    logic [2:0]               flags;
    logic [COLOR_DEPTH-1:0]   ramp_v;
    logic                     grid_hit;
    logic                     in_bar;
    logic [3*COLOR_DEPTH-1:0] pix;

    assign grid_hit = (x1_q[GRID_LOG2-1:0] == '0) || (y1_q[GRID_LOG2-1:0] == '0) ||
                      (x1_q == X_BITS'(H_ACT - 1)) || (y1_q == Y_BITS'(V_ACT - 1));

    // Extra bit keeps bar_pos+BAR_W from wrapping, so the bar clips at the right edge
    assign in_bar = ({1'b0, x1_q} >= {1'b0, bar_pos}) &&
                    ({1'b0, x1_q} <  ({1'b0, bar_pos} + (X_BITS+1)'(BAR_W)));

    always_comb begin
        mode_d  = frame_start ? pvg_mode_e'(mode_in) : mode_q;
        color_d = frame_start ? color_in : color_q;
        x1_d    = x_cnt;
        y1_d    = y_cnt;
        de1_d   = de_in;
        hs1_d   = hs_in;
        vs1_d   = vs_in;

        // Descending scan leaves the first bar whose right edge lies beyond x; overlong lines land in bar 7
        bar_idx = 3'd7;
        for (int k = 6; k >= 0; k--) begin
            if (int'(x1_q) < (k + 1) * BAR_W) begin
                bar_idx = 3'(k);
            end
        end
        flags  = bar_flags(bar_idx);
        ramp_v = COLOR_DEPTH'(x1_q >> RAMP_SHIFT);

        case (mode_q)
            MODE_SOLID: pix = color_q;
            MODE_BARS:  pix = {{COLOR_DEPTH{flags[2]}}, {COLOR_DEPTH{flags[1]}}, {COLOR_DEPTH{flags[0]}}};
            MODE_RAMP:  pix = {ramp_v, ramp_v, ramp_v};
            MODE_CHECK: pix = (x1_q[CHECK_LOG2] ^ y1_q[CHECK_LOG2]) ? WHITE : '0;
            MODE_GRID:  pix = grid_hit ? WHITE : '0;
            MODE_MOVE:  pix = in_bar ? WHITE : '0;
            default:    pix = '0;
        endcase

`ifdef PATTERN_VG_BORDER_EN
        if ((x1_q == '0) || (x1_q == X_BITS'(H_ACT - 1)) ||
            (y1_q == '0) || (y1_q == Y_BITS'(V_ACT - 1))) begin
            pix = WHITE;
        end
`endif

        vs2_d  = vs1_q;
        hs2_d  = hs1_q;
        de2_d  = de1_q;
        rgb2_d = de1_q ? pix : '0;
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_SOLID;
            color_q <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            de1_q   <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            de2_q   <= 1'b0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            rgb2_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            color_q <= color_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            de1_q   <= de1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            de2_q   <= de2_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            rgb2_q  <= rgb2_d;
        end
    end

    assign vs_out = vs2_q;
    assign hs_out = hs2_q;
    assign de_out = de2_q;
    assign r_out  = rgb2_q[3*COLOR_DEPTH-1 -: COLOR_DEPTH];
    assign g_out  = rgb2_q[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
    assign b_out  = rgb2_q[COLOR_DEPTH-1:0];

endmodule

// File: tb/tb_pattern_vg_multi.sv
// Directed scoreboard bench for pattern_vg_multi on a 64x8 raster with 8-pixel bars.
module tb_pattern_vg_multi;
    import pattern_vg_pkg::*;

    localparam int HA = 64;
    localparam int VA = 8;
    localparam int BW = HA / 8;

    logic        pix_clk = 1'b0;
    logic        rst;
    logic [2:0]  mode_in;
    logic [23:0] color_in;
    logic        vs_in, hs_in, de_in;
    logic        vs_out, hs_out, de_out;
    logic [7:0]  r_out, g_out, b_out;

    typedef struct {
        logic [26:0] v;
        int          mode;
        int          x;
        int          y;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          m_mode;
    logic [23:0] m_color;
    int          m_bar;

    always #5 pix_clk = ~pix_clk;

    pattern_vg_multi #(
        .COLOR_DEPTH (8),
        .X_BITS      (13),
        .Y_BITS      (13),
        .H_ACT       (HA),
        .V_ACT       (VA),
        .CHECK_LOG2  (2),
        .GRID_LOG2   (3),
        .RAMP_SHIFT  (2),
        .MOVE_STEP   (4)
    ) dut (
        .pix_clk  (pix_clk),
        .rst      (rst),
        .mode_in  (mode_in),
        .color_in (color_in),
        .vs_in    (vs_in),
        .hs_in    (hs_in),
        .de_in    (de_in),
        .vs_out   (vs_out),
        .hs_out   (hs_out),
        .de_out   (de_out),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out)
    );

    function automatic logic [23:0] model_rgb(input int mode, input logic [23:0] col,
                                              input int x, input int y, input int bar);
        logic [2:0] f;
        logic [7:0] v;
        int         k;
        case (mode)
            0: return col;
            1: begin
                k = x / BW;
                if (k > 7) k = 7;
                case (k)
                    0: f = 3'b111;  // white
                    1: f = 3'b110;  // yellow
                    2: f = 3'b011;  // cyan
                    3: f = 3'b010;  // green
                    4: f = 3'b101;  // magenta
                    5: f = 3'b100;  // red
                    6: f = 3'b001;  // blue
                    default: f = 3'b000;
                endcase
                return {{8{f[2]}}, {8{f[1]}}, {8{f[0]}}};
            end
            2: begin
                v = 8'(x >> 2);
                return {v, v, v};
            end
            3: return ((((x >> 2) ^ (y >> 2)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            4: return ((x % 8 == 0) || (y % 8 == 0) || (x == HA - 1) || (y == VA - 1)) ? 24'hFFFFFF : 24'h0;
            5: return ((x >= bar) && (x < bar + BW)) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input int x, input int y);
        exp_t e;
        exp_t o;
        @(negedge pix_clk);
        vs_in = vs;
        hs_in = hs;
        de_in = de;
        e.v    = {vs, hs, de, (de ? model_rgb(m_mode, m_color, x, y, m_bar) : 24'h0)};
        e.mode = m_mode;
        e.x    = x;
        e.y    = y;
        sb.push_back(e);
        if (sb.size() > PVG_LATENCY) begin
            o = sb.pop_front();
            chk($sformatf("pix_m%0d_x%0d_y%0d", o.mode, o.x, o.y),
                {vs_out, hs_out, de_out, r_out, g_out, b_out}, o.v);
        end
    endtask

    task automatic vs_rise();
        m_mode  = int'(mode_in);
        m_color = color_in;
        m_bar   = m_bar + 4;
        if (m_bar >= HA) m_bar = m_bar - HA;
        step(1, 0, 0, 0, 0);
    endtask

    task automatic frame(input int nlines, input int npix, input int sw_line,
                         input logic [2:0] sw_mode, input logic [23:0] sw_color);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        vs_rise();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int y = 0; y < nlines; y++) begin
            if (y == sw_line) begin
                mode_in  = sw_mode;
                color_in = sw_color;
            end
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            for (int x = 0; x < npix; x++) step(0, 0, 1, x, y);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        mode_in  = 3'd0;
        color_in = 24'h0;
        vs_in    = 1'b0;
        hs_in    = 1'b0;
        de_in    = 1'b0;
        m_mode   = 0;
        m_color  = 24'h0;
        m_bar    = 0;
        repeat (3) @(negedge pix_clk);
        chk("reset_outputs", {vs_out, hs_out, de_out, r_out, g_out, b_out}, 27'h0);
        rst = 1'b0;

        // Solid colour; colour change mid-frame must not take effect
        mode_in  = 3'd0;
        color_in = 24'h123456;
        frame(VA, HA, 4, 3'd0, 24'hABCDEF);
        color_in = 24'h123456;
        frame(2, HA, -1, 3'd0, 24'h0);

        // Colour bars, then a switch to checkerboard mid-frame that waits for the next vs
        mode_in = 3'd1;
        frame(VA, HA, 4, 3'd3, 24'h0);
        frame(VA, HA, -1, 3'd0, 24'h0);

        // Ramp and bars with overlong lines
        mode_in = 3'd2;
        frame(2, 70, -1, 3'd0, 24'h0);
        mode_in = 3'd1;
        frame(1, 70, -1, 3'd0, 24'h0);

        // Crosshatch, then the two blank modes
        mode_in = 3'd4;
        frame(VA, HA, -1, 3'd0, 24'h0);
        mode_in  = 3'd6;
        color_in = 24'hFFFFFF;
        frame(1, HA, -1, 3'd0, 24'h0);
        mode_in = 3'd7;
        frame(1, HA, -1, 3'd0, 24'h0);

        // Moving bar over enough frames to wrap its position
        mode_in = 3'd5;
        for (int f = 0; f < 17; f++) frame(1, HA, -1, 3'd0, 24'h0);

        // Reset in the middle of a bar line
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        vs_rise();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int x = 0; x < 20; x++) step(0, 0, 1, x, 0);
        @(posedge pix_clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midline_reset", {vs_out, hs_out, de_out, r_out, g_out, b_out}, 27'h0);
        sb.delete();
        de_in = 1'b0;
        hs_in = 1'b0;
        vs_in = 1'b0;
        repeat (3) @(negedge pix_clk);
        rst     = 1'b0;
        m_mode  = 0;
        m_color = 24'h0;
        m_bar   = 0;

        // Before any vs edge the output is solid black, then the bar restarts at x=4
        step(0, 0, 0, 0, 0);
        for (int x = 0; x < 16; x++) step(0, 0, 1, x, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        frame(1, HA, -1, 3'd0, 24'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
